// File: rtl/mem_stage_pkg.sv
// Shared widths and the registered load-command payload for the memory stage.
package mem_stage_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 12;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_AW         = 5;
    localparam int unsigned MASK_W         = 4;

    // Everything a load needs after the upstream stage has moved on.
    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MASK_W-1:0]         mask;
        logic                      sign_ext;
        logic                      rd_we;
        logic [REG_AW-1:0]         rd_addr;
    } load_cmd_t;

endpackage

// File: rtl/mem_load_align.sv
// Load-data formatter: picks lanes by mask (lane 3 = byte offset 0), then sign/zero extends.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0]   rdata_i,
    input  logic [MASK_W-1:0] mask_i,
    input  logic              sign_ext_i,
    output logic [XLEN-1:0]   data_o
);

    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic        is_half;
    logic        is_byte;

    always_comb begin
        half     = '0;
        byte_sel = '0;
        is_half  = 1'b0;
        is_byte  = 1'b0;
        data_o   = '0;
        case (mask_i)
            4'b1111: data_o = {rdata_i[7:0], rdata_i[15:8], rdata_i[23:16], rdata_i[31:24]};
            4'b1100: begin half = {rdata_i[23:16], rdata_i[31:24]}; is_half = 1'b1; end
            4'b0011: begin half = {rdata_i[7:0], rdata_i[15:8]};    is_half = 1'b1; end
            4'b1000: begin byte_sel = rdata_i[31:24]; is_byte = 1'b1; end
            4'b0100: begin byte_sel = rdata_i[23:16]; is_byte = 1'b1; end
            4'b0010: begin byte_sel = rdata_i[15:8];  is_byte = 1'b1; end
            4'b0001: begin byte_sel = rdata_i[7:0];   is_byte = 1'b1; end
            default: data_o = '0;
        endcase
        // Misaligned (and any other) masks fall through as zero.
        if (is_half) begin
            data_o = {{16{sign_ext_i & half[15]}}, half};
        end else if (is_byte) begin
            data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-RAM accesses, stalls for load latency, registers writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    output logic                      stall_o,
    input  logic                      rd_we_i,
    input  logic [REG_AW-1:0]         rd_addr_i,
    input  logic [XLEN-1:0]           rd_data_i,
    input  logic                      ram_we_i,
    input  logic                      ram_re_i,
    input  logic [MEM_ADDR_WIDTH-1:0] ram_wr_addr_i,
    input  logic [XLEN-1:0]           ram_w_data_i,
    input  logic [MASK_W-1:0]         ram_wr_mask_i,
    input  logic                      ram_r_sign_ext_i,
    output logic                      bram_en,
    output logic [MASK_W-1:0]         bram_we,
    output logic [MEM_ADDR_WIDTH-1:0] bram_addr,
    output logic [XLEN-1:0]           bram_wdata,
    input  logic [XLEN-1:0]           bram_rdata,
    output logic                      wb_valid,
    output logic                      wb_rd_we,
    output logic [REG_AW-1:0]         wb_rd_addr,
    output logic [XLEN-1:0]           wb_rd_data
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic {IDLE, LOAD_WAIT} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stall_q;
    load_cmd_t         ld_q;
    logic              wb_valid_q;
    logic              wb_rd_we_q;
    logic [REG_AW-1:0] wb_rd_addr_q;
    logic [XLEN-1:0]   wb_rd_data_q;

    logic              accept;
    logic              is_load;
    logic [XLEN-1:0]   load_data;

    // A store wins when both read and write are requested.
    assign accept  = rst & valid_i & (state_q == IDLE);
    assign is_load = ram_re_i & ~ram_we_i;

    mem_load_align u_align (
        .rdata_i    (bram_rdata),
        .mask_i     (ld_q.mask),
        .sign_ext_i (ld_q.sign_ext),
        .data_o     (load_data)
    );

    // RAM port: live command when accepting, frozen load copy while waiting.
    always_comb begin
        bram_en    = 1'b0;
        bram_we    = '0;
        bram_addr  = ram_wr_addr_i;
        bram_wdata = ram_w_data_i;
        if (state_q == LOAD_WAIT) begin
            bram_en   = rst;
            bram_addr = ld_q.addr;
        end else if (accept && (ram_we_i || ram_re_i)) begin
            bram_en = 1'b1;
            if (ram_we_i) begin
                bram_we = ram_wr_mask_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            stall_q      <= 1'b0;
            ld_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_we_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_data_q <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && is_load) begin
                        state_q       <= LOAD_WAIT;
                        stall_q       <= 1'b1;
                        cnt_q         <= CNT_W'(RD_LAT - 1);
                        ld_q.addr     <= ram_wr_addr_i;
                        ld_q.mask     <= ram_wr_mask_i;
                        ld_q.sign_ext <= ram_r_sign_ext_i;
                        ld_q.rd_we    <= rd_we_i;
                        ld_q.rd_addr  <= rd_addr_i;
                    end else if (accept) begin
                        wb_valid_q   <= 1'b1;
                        wb_rd_we_q   <= rd_we_i & ~ram_we_i & (rd_addr_i != '0);
                        wb_rd_addr_q <= rd_addr_i;
                        wb_rd_data_q <= rd_data_i;
                    end
                end
                LOAD_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= IDLE;
                        stall_q      <= 1'b0;
                        wb_valid_q   <= 1'b1;
                        wb_rd_we_q   <= ld_q.rd_we & (ld_q.rd_addr != '0);
                        wb_rd_addr_q <= ld_q.rd_addr;
                        wb_rd_data_q <= load_data;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o    = stall_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd_we   = wb_rd_we_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_rd_data = wb_rd_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, corner sequences and a randomized model run.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int unsigned AW = MEM_ADDR_WIDTH;

    typedef struct {
        logic          valid;
        logic          rd_we;
        logic [4:0]    rd_addr;
        logic [31:0]   rd_data;
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    mask;
        logic          sext;
    } instr_t;

    typedef struct {
        string       name;
        instr_t      ins;
        logic        preload;
        logic [31:0] word;
        logic [3:0]  exp_bwe;
        logic        exp_we;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic sel;

    logic          valid_i, rd_we_i, ram_we_i, ram_re_i, ram_r_sign_ext_i;
    logic [4:0]    rd_addr_i;
    logic [31:0]   rd_data_i, ram_w_data_i, bram_rdata;
    logic [AW-1:0] ram_wr_addr_i;
    logic [3:0]    ram_wr_mask_i;

    logic          stall_w    [2];
    logic          bram_en_w  [2];
    logic [3:0]    bram_we_w  [2];
    logic [AW-1:0] bram_addr_w[2];
    logic [31:0]   bram_wd_w  [2];
    logic          wbv_w      [2];
    logic          wbwe_w     [2];
    logic [4:0]    wba_w      [2];
    logic [31:0]   wbd_w      [2];

    logic          stall_o, bram_en, wb_valid, wb_rd_we;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata, wb_rd_data;
    logic [4:0]    wb_rd_addr;

    mem_stage #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_w[0]),
        .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
        .ram_we_i(ram_we_i), .ram_re_i(ram_re_i), .ram_wr_addr_i(ram_wr_addr_i),
        .ram_w_data_i(ram_w_data_i), .ram_wr_mask_i(ram_wr_mask_i), .ram_r_sign_ext_i(ram_r_sign_ext_i),
        .bram_en(bram_en_w[0]), .bram_we(bram_we_w[0]), .bram_addr(bram_addr_w[0]),
        .bram_wdata(bram_wd_w[0]), .bram_rdata(bram_rdata),
        .wb_valid(wbv_w[0]), .wb_rd_we(wbwe_w[0]), .wb_rd_addr(wba_w[0]), .wb_rd_data(wbd_w[0])
    );

    mem_stage #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_w[1]),
        .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
        .ram_we_i(ram_we_i), .ram_re_i(ram_re_i), .ram_wr_addr_i(ram_wr_addr_i),
        .ram_w_data_i(ram_w_data_i), .ram_wr_mask_i(ram_wr_mask_i), .ram_r_sign_ext_i(ram_r_sign_ext_i),
        .bram_en(bram_en_w[1]), .bram_we(bram_we_w[1]), .bram_addr(bram_addr_w[1]),
        .bram_wdata(bram_wd_w[1]), .bram_rdata(bram_rdata),
        .wb_valid(wbv_w[1]), .wb_rd_we(wbwe_w[1]), .wb_rd_addr(wba_w[1]), .wb_rd_data(wbd_w[1])
    );

    // Observe whichever instance the current phase targets.
    always_comb begin
        stall_o    = stall_w[sel];
        bram_en    = bram_en_w[sel];
        bram_we    = bram_we_w[sel];
        bram_addr  = bram_addr_w[sel];
        bram_wdata = bram_wd_w[sel];
        wb_valid   = wbv_w[sel];
        wb_rd_we   = wbwe_w[sel];
        wb_rd_addr = wba_w[sel];
        wb_rd_data = wbd_w[sel];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-enabled data RAM with a read pipeline matching the observed instance.
    logic        pl_en;
    logic [3:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] ram  [16];
    logic [31:0] pipe [1:3];

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (bram_en) begin
            for (int i = 0; i < 4; i++)
                if (bram_we[i]) ram[bram_addr[3:0]][8*i +: 8] <= bram_wdata[8*i +: 8];
        end
        pipe[1] <= ram[bram_addr[3:0]];
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
    end

    always_comb bram_rdata = sel ? pipe[3] : pipe[1];

    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    int          n_chk;
    int          n_fail;
    exp_t        q[$];
    exp_t        last;
    int          stall_end;
    logic [AW-1:0] held_addr;
    logic [31:0] mem_m [16];
    logic [4:0]  wb_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference load formatter: gather selected bytes in address order, little-endian, then extend.
    function automatic logic [31:0] ref_align(logic [31:0] w, logic [3:0] m, logic s);
        logic [31:0] r;
        logic [7:0]  b;
        int          n;
        r = '0;
        n = 0;
        if (!(m inside {4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1})) return '0;
        for (int off = 0; off < 4; off++) begin
            if (m[3-off]) begin
                b = w[31-8*off -: 8];
                r = r | (32'(b) << (8*n));
                n++;
            end
        end
        if (s && n < 4 && r[8*n-1]) r = r | ~((32'd1 << (8*n)) - 32'd1);
        return r;
    endfunction

    function automatic instr_t alu(logic [4:0] rd, logic we, logic [31:0] d);
        instr_t r;
        r = '{valid: 1'b1, rd_we: we, rd_addr: rd, rd_data: d, we: 1'b0, re: 1'b0,
              addr: AW'(1), wdata: 32'h0, mask: 4'hF, sext: 1'b0};
        return r;
    endfunction

    function automatic instr_t ld(logic [4:0] rd, logic [AW-1:0] a, logic [3:0] m, logic s);
        instr_t r;
        r = '{valid: 1'b1, rd_we: 1'b1, rd_addr: rd, rd_data: 32'hBAD0BAD0, we: 1'b0, re: 1'b1,
              addr: a, wdata: 32'h0, mask: m, sext: s};
        return r;
    endfunction

    function automatic instr_t st(logic [AW-1:0] a, logic [3:0] m, logic [31:0] wd, logic re);
        instr_t r;
        r = '{valid: 1'b1, rd_we: 1'b1, rd_addr: 5'd9, rd_data: 32'h5A5A5A5A, we: 1'b1, re: re,
              addr: a, wdata: wd, mask: m, sext: 1'b0};
        return r;
    endfunction

    function automatic instr_t idle();
        instr_t r;
        r = alu(5'd0, 1'b0, 32'h0);
        r.valid = 1'b0;
        return r;
    endfunction

    function automatic instr_t rnd_ins();
        instr_t     r;
        int         k;
        logic [3:0] masks[8];
        masks = '{4'hF, 4'hC, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
        k = $urandom_range(0, 9);
        r.valid   = ($urandom_range(0, 9) < 7);
        r.rd_we   = 1'($urandom_range(0, 1));
        r.rd_addr = 5'($urandom);
        r.rd_data = $urandom;
        r.addr    = AW'($urandom_range(0, 15));
        r.wdata   = $urandom;
        r.mask    = masks[$urandom_range(0, 7)];
        r.sext    = 1'($urandom_range(0, 1));
        r.we      = (k < 2);
        r.re      = (k == 0) || (k >= 2 && k < 5);
        return r;
    endfunction

    task automatic drive(input instr_t i);
        valid_i          = i.valid;
        rd_we_i          = i.rd_we;
        rd_addr_i        = i.rd_addr;
        rd_data_i        = i.rd_data;
        ram_we_i         = i.we;
        ram_re_i         = i.re;
        ram_wr_addr_i    = i.addr;
        ram_w_data_i     = i.wdata;
        ram_wr_mask_i    = i.mask;
        ram_r_sign_ext_i = i.sext;
    endtask

    task automatic model_reset();
        q.delete();
        wb_log.delete();
        last      = '{due: 0, we: 1'b0, addr: 5'd0, data: 32'h0};
        stall_end = -1;
        held_addr = '0;
    endtask

    task automatic do_reset(input logic s);
        sel = s;
        @(negedge clk);
        rst = 1'b0;
        drive(idle());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] w);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = w;
        mem_m[a] = w;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_stall"}, stall_o, 1'b0);
        chk({tag, "_wbv"},   wb_valid, 1'b0);
        chk({tag, "_wbwe"},  wb_rd_we, 1'b0);
        chk({tag, "_wba"},   wb_rd_addr, 5'd0);
        chk({tag, "_wbd"},   wb_rd_data, 32'h0);
        chk({tag, "_en"},    bram_en, 1'b0);
        chk({tag, "_we"},    bram_we, 4'h0);
    endtask

    // One model-checked cycle: present ins, compare every output against the reference.
    task automatic mstep(input instr_t ins, output logic accepted);
        logic exp_v;
        logic stalled;
        int   lat;
        lat = sel ? 3 : 1;
        @(posedge clk); #1;
        drive(ins);
        @(negedge clk);
        if (wb_valid === 1'b1) wb_log.push_back(wb_rd_addr);
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        chk("wb_valid", wb_valid, exp_v);
        if (exp_v) last = q.pop_front();
        chk("wb_rd_we", wb_rd_we, last.we);
        chk("wb_rd_addr", wb_rd_addr, last.addr);
        chk("wb_rd_data", wb_rd_data, last.data);
        stalled = (cyc <= stall_end);
        chk("stall", stall_o, stalled);
        accepted = ins.valid && !stalled;
        if (stalled) begin
            chk("hold_en", bram_en, 1'b1);
            chk("hold_we", bram_we, 4'h0);
            chk("hold_addr", bram_addr, held_addr);
        end else if (ins.valid && ins.we) begin
            chk("st_en", bram_en, 1'b1);
            chk("st_we", bram_we, ins.mask);
            chk("st_addr", bram_addr, ins.addr);
            chk("st_wdata", bram_wdata, ins.wdata);
            for (int i = 0; i < 4; i++)
                if (ins.mask[i]) mem_m[ins.addr[3:0]][8*i +: 8] = ins.wdata[8*i +: 8];
            q.push_back('{due: cyc + 1, we: 1'b0, addr: ins.rd_addr, data: ins.rd_data});
        end else if (ins.valid && ins.re) begin
            chk("ld_en", bram_en, 1'b1);
            chk("ld_we", bram_we, 4'h0);
            chk("ld_addr", bram_addr, ins.addr);
            stall_end = cyc + lat;
            held_addr = ins.addr;
            q.push_back('{due: cyc + lat + 1, we: ins.rd_we && (ins.rd_addr != 0), addr: ins.rd_addr,
                          data: ref_align(mem_m[ins.addr[3:0]], ins.mask, ins.sext)});
        end else begin
            chk("nomem_en", bram_en, 1'b0);
            chk("nomem_we", bram_we, 4'h0);
            if (ins.valid)
                q.push_back('{due: cyc + 1, we: ins.rd_we && (ins.rd_addr != 0), addr: ins.rd_addr,
                              data: ins.rd_data});
        end
    endtask

    // Directed vector on the RD_LAT=1 instance: accept-cycle RAM drive, then retire latency and data.
    task automatic run_vec(input vec_t v);
        int got;
        if (v.preload) preload(v.ins.addr[3:0], v.word);
        @(posedge clk); #1;
        drive(v.ins);
        @(negedge clk);
        chk({v.name, "_stall0"}, stall_o, 1'b0);
        chk({v.name, "_bwe"}, bram_we, v.exp_bwe);
        chk({v.name, "_ben"}, bram_en, v.ins.we | v.ins.re);
        @(posedge clk); #1;
        drive(idle());
        got = 0;
        for (int k = 1; k <= 8 && got == 0; k++) begin
            @(negedge clk);
            if (k == 1 && v.exp_lat > 1) chk({v.name, "_stall1"}, stall_o, 1'b1);
            if (wb_valid === 1'b1) got = k;
        end
        chk({v.name, "_lat"}, got, v.exp_lat);
        chk({v.name, "_data"}, wb_rd_data, v.exp_data);
        chk({v.name, "_we"}, wb_rd_we, v.exp_we);
    endtask

    vec_t vq[$];

    task automatic add_vec(input string nm, input instr_t i, input logic pre, input logic [31:0] w,
                           input logic [3:0] bwe, input logic we, input logic [31:0] d, input int lat);
        vec_t v;
        v.name = nm; v.ins = i; v.preload = pre; v.word = w;
        v.exp_bwe = bwe; v.exp_we = we; v.exp_data = d; v.exp_lat = lat;
        vq.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   tries;
        n_chk  = 0;
        n_fail = 0;
        pl_en  = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        sel    = 1'b0;
        rst    = 1'b0;
        model_reset();
        drive(st(AW'(5), 4'hF, 32'h12345678, 1'b0));
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk_reset_outs("por");
        end

        // Directed vectors, RD_LAT=1.
        do_reset(1'b0);
        add_vec("sw",      st(AW'(5), 4'hF, 32'h44332211, 1'b0), 0, 32'h0,        4'hF, 0, 32'h5A5A5A5A, 1);
        add_vec("lw",      ld(5'd10, AW'(6), 4'hF, 1'b0),  1, 32'h11223344, 4'h0, 1, 32'h44332211, 2);
        add_vec("lb",      ld(5'd11, AW'(7), 4'h4, 1'b1),  1, 32'h00800000, 4'h0, 1, 32'hFFFFFF80, 2);
        add_vec("lbu",     ld(5'd11, AW'(7), 4'h4, 1'b0),  0, 32'h0,        4'h0, 1, 32'h00000080, 2);
        add_vec("lh",      ld(5'd12, AW'(8), 4'h3, 1'b1),  1, 32'h000080FF, 4'h0, 1, 32'hFFFFFF80, 2);
        add_vec("lh_hi",   ld(5'd12, AW'(9), 4'hC, 1'b1),  1, 32'h80010000, 4'h0, 1, 32'h00000180, 2);
        add_vec("lb_l3",   ld(5'd13, AW'(10), 4'h8, 1'b1), 1, 32'h9A000000, 4'h0, 1, 32'hFFFFFF9A, 2);
        add_vec("lb_l1",   ld(5'd13, AW'(11), 4'h2, 1'b1), 1, 32'h0000C300, 4'h0, 1, 32'hFFFFFFC3, 2);
        add_vec("lb_l0",   ld(5'd13, AW'(12), 4'h1, 1'b1), 1, 32'h0000007F, 4'h0, 1, 32'h0000007F, 2);
        add_vec("lw_mis",  ld(5'd14, AW'(13), 4'h0, 1'b1), 1, 32'hFFFFFFFF, 4'h0, 1, 32'h00000000, 2);
        add_vec("add_x0",  alu(5'd0, 1'b1, 32'h5),         0, 32'h0,        4'h0, 0, 32'h00000005, 1);
        add_vec("add",     alu(5'd3, 1'b1, 32'hDEADBEEF),  0, 32'h0,        4'h0, 1, 32'hDEADBEEF, 1);
        add_vec("lw_x0",   ld(5'd0, AW'(14), 4'hF, 1'b0),  1, 32'h01020304, 4'h0, 0, 32'h04030201, 2);
        add_vec("st_rdwr", st(AW'(15), 4'h3, 32'h0000BEEF, 1'b1), 0, 32'h0, 4'h3, 0, 32'h5A5A5A5A, 1);
        add_vec("lw_back", ld(5'd1, AW'(5), 4'hF, 1'b0),   0, 32'h0,        4'h0, 1, 32'h11223344, 2);
        for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

        // Back-to-back ALU, load, ALU on the RD_LAT=3 instance.
        do_reset(1'b1);
        preload(4'd3, 32'hA1B2C3D4);
        tries = 0;
        do begin mstep(alu(5'd1, 1'b1, 32'h11), acc); tries++; end while (!acc && tries < 10);
        tries = 0;
        do begin mstep(ld(5'd2, AW'(3), 4'hF, 1'b0), acc); tries++; end while (!acc && tries < 10);
        tries = 0;
        do begin mstep(alu(5'd3, 1'b1, 32'h33), acc); tries++; end while (!acc && tries < 10);
        chk("add2_presented", tries, 4);
        for (int i = 0; i < 6; i++) mstep(idle(), acc);
        chk("b2b_count", wb_log.size(), 3);
        if (wb_log.size() == 3) begin
            chk("b2b_order0", wb_log[0], 5'd1);
            chk("b2b_order1", wb_log[1], 5'd2);
            chk("b2b_order2", wb_log[2], 5'd3);
        end

        // Reset asserted while a load is waiting on the RD_LAT=3 instance.
        do_reset(1'b1);
        mstep(alu(5'd4, 1'b1, 32'hABCD0123), acc);
        mstep(ld(5'd6, AW'(3), 4'hF, 1'b0), acc);
        mstep(idle(), acc);
        #2;
        rst = 1'b0;
        drive(st(AW'(2), 4'hF, 32'hFFFFFFFF, 1'b0));
        #1;
        chk_reset_outs("rst_mid");
        @(posedge clk); #1;
        chk_reset_outs("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        drive(idle());
        model_reset();
        for (int i = 0; i < 6; i++) mstep(idle(), acc);

        // Randomized traffic against the reference model, both latencies.
        for (int s = 0; s < 2; s++) begin
            do_reset(1'(s));
            for (int a = 0; a < 16; a++) preload(4'(a), $urandom);
            for (int i = 0; i < 300; i++) mstep(rnd_ins(), acc);
            for (int i = 0; i < 6; i++) mstep(idle(), acc);
            chk("drain_empty", q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
